// File: rtl/angle_quadrant_reducer.sv
// Angle range reduction: data_in mod 360 folded into a quadrant plus a
// first-quadrant reference angle (0..90), registered with one cycle of latency.
module angle_quadrant_reducer #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en_divider,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [1:0]            quadrant,
  output logic [DATA_WIDTH-1:0] data_out
);

  // x mod 360 = 8*((x>>3) mod 45) + x[2:0]; since 2^12 == 1 (mod 45),
  // (x>>3) mod 45 equals the sum of its 12-bit chunks mod 45.
  localparam int QW  = DATA_WIDTH - 3;
  localparam int NCH = (QW + 11) / 12;
  localparam int PW  = NCH * 12;
  localparam int SW  = 12 + $clog2(NCH) + 1;

  logic [PW-1:0]         q_pad;
  logic [SW-1:0]         chunk_sum;
  logic [12:0]           fold;
  logic [12:0]           rem45;
  logic [8:0]            r;
  logic [6:0]            ref_ang;
  logic [1:0]            quad;
  logic [1:0]            quadrant_d, quadrant_q;
  logic [DATA_WIDTH-1:0] data_out_d, data_out_q;

  always_comb begin
    q_pad     = PW'(data_in[DATA_WIDTH-1:3]);
    chunk_sum = '0;
    for (int i = 0; i < NCH; i++)
      chunk_sum = chunk_sum + SW'(q_pad[i*12 +: 12]);
    // Second fold leaves at most 4095 + NCH, well below 45*128.
    fold  = 13'(chunk_sum[11:0]) + 13'(chunk_sum >> 12);
    rem45 = fold;
    for (int k = 6; k >= 0; k--)
      if (rem45 >= 13'(45 << k)) rem45 = rem45 - 13'(45 << k);
    r = 9'({rem45, data_in[2:0]});
  end

  always_comb begin
    quad    = 2'd0;
    ref_ang = 7'(r);
    if (r < 9'd90) begin
      quad    = 2'd0;
      ref_ang = 7'(r);
    end else if (r < 9'd180) begin
      quad    = 2'd1;
      ref_ang = 7'(9'd180 - r);
    end else if (r < 9'd270) begin
      quad    = 2'd2;
      ref_ang = 7'(r - 9'd180);
    end else begin
      quad    = 2'd3;
      ref_ang = 7'(9'd360 - r);
    end
  end

  always_comb begin
    quadrant_d = quadrant_q;
    data_out_d = data_out_q;
    if (en_divider) begin
      quadrant_d = quad;
      data_out_d = DATA_WIDTH'(ref_ang);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quadrant_q <= 2'd0;
      data_out_q <= '0;
    end else begin
      quadrant_q <= quadrant_d;
      data_out_q <= data_out_d;
    end
  end

  assign quadrant = quadrant_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_angle_quadrant_reducer.sv
// Scoreboard bench for angle_quadrant_reducer: driver queues expectations,
// monitor pops one per enabled edge and checks outputs every cycle.
module tb_angle_quadrant_reducer;

  localparam int DW = 64;

  typedef struct packed {
    logic [1:0]    q;
    logic [DW-1:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en_divider;
  logic [DW-1:0] data_in;
  logic [1:0]    quadrant;
  logic [DW-1:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  angle_quadrant_reducer #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .en_divider(en_divider),
    .data_in(data_in), .quadrant(quadrant), .data_out(data_out)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [DW-1:0] v);
    exp_t e;
    logic [DW-1:0] r;
    r = v % 360;
    if (r < 90)       begin e.q = 2'd0; e.d = r;       end
    else if (r < 180) begin e.q = 2'd1; e.d = 180 - r; end
    else if (r < 270) begin e.q = 2'd2; e.d = r - 180; end
    else              begin e.q = 2'd3; e.d = 360 - r; end
    return e;
  endfunction

  task automatic check(input string nm, input exp_t e);
    n_cmp++;
    if (quadrant !== e.q || data_out !== e.d) begin
      n_bad++;
      $display("FAIL %s: got Q%0d/%0d expected Q%0d/%0d (t=%0t)",
               nm, quadrant, data_out, e.q, e.d, $time);
    end
  endtask

  // One call per clock edge; inputs change 1 time unit after the edge.
  task automatic drive_exp(input logic e, input logic [DW-1:0] v,
                           input logic [1:0] xq, input logic [DW-1:0] xd);
    exp_t x;
    x.q = xq; x.d = xd;
    en_divider = e;
    data_in    = v;
    if (e) sb.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic e, input logic [DW-1:0] v);
    exp_t x;
    x = model(v);
    drive_exp(e, v, x.q, x.d);
  endtask

  // Monitor: an edge with en high consumes one queue entry; it is kept only
  // if reset was high at that edge, otherwise outputs must read zero.
  initial begin : monitor
    exp_t last, e;
    logic ld_en, ld_rst;
    last = '0;
    forever begin
      @(posedge clk);
      ld_en  = en_divider;
      ld_rst = reset_n;
      @(negedge clk);
      e = '0;
      if (ld_en) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_underflow: got empty queue expected an entry (t=%0t)", $time);
        end else e = sb.pop_front();
      end
      if (!ld_rst || !reset_n) last = '0;
      else if (ld_en) last = e;
      check("cycle", last);
    end
  end

  int cp_v[12] = '{0, 45, 90, 135, 180, 225, 270, 315, 360, 450, 630, 720};
  int cp_q[12] = '{0, 0,  1,  1,   2,   2,   3,   3,   0,   1,   3,   0};
  int cp_d[12] = '{0, 45, 90, 45,  0,   45,  90,  45,  0,   90,  90,  0};

  initial begin : stim
    exp_t z;
    bit hit;
    z = '0;
    reset_n = 1'b0; en_divider = 1'b1; data_in = 100;
    sb.push_back(model(100));
    @(posedge clk); #1;
    check("reset_hold", z);
    drive(1'b1, 100);
    check("reset_hold2", z);
    reset_n = 1'b1;

    // Quadrant sweep 0..720 in steps of 5, hand values at checkpoints
    for (int v = 0; v <= 720; v += 5) begin
      hit = 1'b0;
      for (int i = 0; i < 12; i++)
        if (cp_v[i] == v) begin
          drive_exp(1'b1, DW'(v), 2'(cp_q[i]), DW'(cp_d[i]));
          hit = 1'b1;
        end
      if (!hit) drive(1'b1, DW'(v));
    end

    drive_exp(1'b1, 89,  2'd0, 89);
    drive_exp(1'b1, 179, 2'd1, 1);
    drive_exp(1'b1, 269, 2'd2, 89);
    drive_exp(1'b1, 359, 2'd3, 1);
    drive_exp(1'b1, 361, 2'd0, 1);
    drive_exp(1'b1, 719, 2'd3, 1);

    // Enable hold
    drive_exp(1'b1, 100, 2'd1, 80);
    repeat (3) drive(1'b0, 200);
    drive_exp(1'b1, 200, 2'd2, 20);

    // Largest input: 2^64 == 16 (mod 360), so 2^64-1 -> 15
    drive_exp(1'b1, {DW{1'b1}}, 2'd0, 15);
    drive_exp(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 2'd0, 8);
    for (int i = 0; i < 20; i++) drive(1'b1, DW'($urandom_range(0, 719)));
    for (int i = 0; i < 10; i++) drive(1'b1, {$urandom, $urandom});

    // Asynchronous reset mid-stream: pending result is discarded
    drive_exp(1'b1, 500, 2'd1, 40);
    en_divider = 1'b1; data_in = 250; sb.push_back(model(250));
    #2 reset_n = 1'b0;
    #1 check("async_reset", z);
    @(posedge clk); #1;
    check("reset_low_edge", z);
    reset_n = 1'b1;
    drive(1'b0, 7);
    drive_exp(1'b1, 33, 2'd0, 33);
    drive(1'b0, 0);
    drive(1'b0, 0);

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d entries left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/angle_quadrant_reducer.md
Name: angle_quadrant_reducer

Overview:
- Angle range-reduction front end of the trigonometric calculator.
- Accepts an unsigned integer angle in degrees and reduces it modulo 360.
- Reports which quadrant (0-3) the reduced angle lies in, and the first-quadrant reference angle (0..90) that the downstream sin/cos engine consumes.
- Single registered stage sitting between the input interface and the CORDIC/FPU core.

Parameters:
- DATA_WIDTH, 64, width of the input angle and the output reference angle, in bits (unsigned integer degrees).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en_divider  input  1  enable; when high, data_in is sampled and the outputs are updated.
- data_in  input  DATA_WIDTH  unsigned angle in whole degrees; any value is legal.
- quadrant  output  2  quadrant of the reduced angle, registered.
- data_out  output  DATA_WIDTH  first-quadrant reference angle in degrees, range 0..90, registered.

Behaviour:
- Reset: reset_n low immediately forces quadrant=0 and data_out=0, independent of clk. The outputs stay at 0 while reset_n is low.
- Reduction: r = data_in mod 360, exact for every unsigned DATA_WIDTH value (e.g. 720 -> 0, 719 -> 359).
- Quadrant and reference angle, computed from r:
  - r 0..89: quadrant=0, data_out=r.
  - r 90..179: quadrant=1, data_out=180-r.
  - r 180..269: quadrant=2, data_out=r-180.
  - r 270..359: quadrant=3, data_out=360-r.
- Boundary values:
  - 0 -> Q0/0
  - 90 -> Q1/90
  - 180 -> Q2/0
  - 270 -> Q3/90
  - 359 -> Q3/1
  - 360 -> Q0/0
- data_out upper bits above bit 6 are always 0.
- Latency: one cycle. On a rising clk edge with reset_n high and en_divider high, both outputs load the result for the data_in value present at that edge. The new values are visible after that edge.
- en_divider low at a rising edge: both outputs hold their previous values.
- Back-to-back operation: a new angle is accepted every cycle; no busy state and no handshake beyond en_divider.
- Reset deasserting coincident with a clock edge: that edge does not load; loading resumes on the first rising edge with reset_n high.
- Reset asserted mid-stream: the result in flight is discarded; outputs are 0 until the next enabled edge after release.
- en_divider or data_in X/unknown: outputs are unspecified; the bench must not drive them so after reset.
- Datapath: combinational mod-360 and quadrant/reference logic feeding a single output register. Any synthesizable structure is acceptable, e.g. constant-modulus reduction or a compare/subtract ladder, as long as it meets the one-cycle latency.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with en_divider=1, data_in=100 -> quadrant=0, data_out=0 throughout. Assert reset_n low asynchronously between edges -> outputs drop to 0 without waiting for clk.
- Quadrant sweep: en=1, data_in=0,5,10,...,720 (145 values), one per cycle -> each result matches the table one cycle later. Checkpoints:
  - 45 -> Q0/45
  - 90 -> Q1/90
  - 135 -> Q1/45
  - 225 -> Q2/45
  - 315 -> Q3/45
  - 360 -> Q0/0
  - 450 -> Q1/90
  - 630 -> Q3/90
  - 720 -> Q0/0
- Boundaries: data_in = 89, 179, 269, 359, 361, 719 -> results:
  - 89 -> Q0/89
  - 179 -> Q1/1
  - 269 -> Q2/89
  - 359 -> Q3/1
  - 361 -> Q0/1
  - 719 -> Q3/1
- Enable hold: load 100 (-> Q1/80), then set en=0 and drive data_in=200 for 3 cycles -> outputs stay Q1/80. Raise en -> next cycle Q2/20.
- Random/large inputs: 20 random values in 0..719, plus data_in = 2^DATA_WIDTH-1 -> each output equals a golden model applying the reduction table to data_in mod 360.
- Throughput: change data_in every cycle with en=1 -> each cycle's output corresponds to the previous cycle's input, with no bubbles.
